// File: rtl/mem_data_arbiter_if.sv
//-----------------------------------------------------------------------------
// mem_data_arbiter_if
//
// Purpose:
//   Bundles every bus-level signal around mem_data_arbiter: the two requester
//   ports (core control FSM and program/data loader), the single data memory
//   port and the busy status flag.
//
// Modports:
//   slave  - arbiter view: requests, request data and memory read data in;
//            grants, responses, memory controls and busy out.
//   master - environment view (requesters and memory): the mirror image.
//
// Signals (per requester <p> = core | ld):
//   <p>_req    request, held until <p>_gnt
//   <p>_we     1 = write, 0 = read
//   <p>_addr   byte address
//   <p>_wdata  write data
//   <p>_gnt    one-cycle pulse: request accepted, access cycle in progress
//   <p>_rvalid one-cycle pulse: access complete
//   <p>_rdata  read data, valid while <p>_rvalid
//   <p>_err    error flag, qualified by <p>_rvalid
// Memory side:
//   mem_addr, mem_wdata, mem_wr (out of arbiter), mem_rdata (into arbiter)
// Status:
//   busy       high whenever the arbiter is not idle
//-----------------------------------------------------------------------------
interface mem_data_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    // core requester
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              core_err;

    // loader requester
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_err;

    // memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    // status
    logic              busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_err,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata, ld_err,
        output mem_addr, mem_wdata, mem_wr,
        input  mem_rdata,
        output busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_err,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
        input  mem_addr, mem_wdata, mem_wr,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_data_arbiter.sv
//-----------------------------------------------------------------------------
// mem_data_arbiter
//
// Purpose:
//   Sequences the single data memory and shares it between the core control
//   FSM ("core") and the program/data loader ("ld"). One access at a time:
//   requests are sampled only while idle, the winner's command is latched,
//   presented to the memory for exactly one cycle, and after MEM_LAT wait
//   cycles the captured read data is returned with a one-cycle valid pulse.
//
//   Timeline for a request sampled in IDLE at cycle T:
//     T+1            ACCESS : <p>_gnt = 1, mem_wr = latched we
//     T+2..T+1+LAT   WAIT   : address held, mem_wr = 0
//     T+2+LAT        RESP   : <p>_rvalid = 1, <p>_rdata = captured data
//
// Parameters:
//   DATA_W    data width of memory and requester buses
//   ADDR_W    address width
//   MEM_LAT   memory read latency in cycles after the access cycle (0..7)
//   CORE_PRIO 1 = core wins every tie, 0 = round-robin on ties
//
// Ports:
//   i_clk   clock
//   i_rst   synchronous, active-high reset
//   io_bus  mem_data_arbiter_if.slave (requesters, memory, busy)
//
// Optional feature (compile-time macro MISALIGN_CHECK_EN):
//   Defined   - a latched address with addr[2:0] != 0 still gets its grant
//               pulse, but the memory write is suppressed and the response
//               carries err = 1 with rdata = 0.
//   Undefined - addresses pass unchanged and the err outputs are tied low.
//-----------------------------------------------------------------------------
module mem_data_arbiter #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int MEM_LAT   = 1,
    parameter int CORE_PRIO = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mem_data_arbiter_if.slave  io_bus
);

    localparam int               CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    // FSM state
    state_t            r_state;
    state_t            w_next_state;

    // Latched command of the current winner
    logic              r_winner_ld;   // 1 = loader owns the access, 0 = core
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Round-robin pointer: 1 = loader was served last, so core wins next tie
    logic              r_last_ld;

    // WAIT down-counter and captured read data
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;

    // Combinational helpers
    logic              w_any_req;
    logic              w_pick_ld;
    logic              w_capture;
    logic              w_misalign;
    logic [DATA_W-1:0] w_resp_data;

    logic              w_core_gnt;
    logic              w_core_rvalid;
    logic [DATA_W-1:0] w_core_rdata;
    logic              w_core_err;
    logic              w_ld_gnt;
    logic              w_ld_rvalid;
    logic [DATA_W-1:0] w_ld_rdata;
    logic              w_ld_err;
    logic              w_mem_wr;

    //-------------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE). A lone request always wins; on a
    // tie the core wins under fixed priority, otherwise the port that was not
    // served last wins.
    //-------------------------------------------------------------------------
    assign w_any_req = io_bus.core_req | io_bus.ld_req;
    assign w_pick_ld = io_bus.ld_req &
                       (~io_bus.core_req | ((CORE_PRIO == 0) & ~r_last_ld));

`ifdef MISALIGN_CHECK_EN
    // Memory is 64-bit word organised: any non-zero byte offset is an error.
    assign w_misalign = (r_addr[2:0] != 3'b000);
`else
    assign w_misalign = 1'b0;
`endif

    // Writes and rejected accesses return zero data.
    assign w_resp_data = (r_we | w_misalign) ? '0 : r_rdata;

    // Read data is sampled on the edge that leaves the last memory cycle,
    // i.e. the last WAIT cycle, or the ACCESS cycle when MEM_LAT is 0.
    assign w_capture = (w_next_state == S_RESP) && (r_state != S_RESP);

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: next state and outputs
    //-------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state  = r_state;
        w_core_gnt    = 1'b0;
        w_core_rvalid = 1'b0;
        w_core_rdata  = '0;
        w_core_err    = 1'b0;
        w_ld_gnt      = 1'b0;
        w_ld_rvalid   = 1'b0;
        w_ld_rdata    = '0;
        w_ld_err      = 1'b0;
        w_mem_wr      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ACCESS;
                end
            end

            S_ACCESS: begin
                w_core_gnt   = ~r_winner_ld;
                w_ld_gnt     = r_winner_ld;
                w_mem_wr     = r_we & ~w_misalign;
                w_next_state = (MEM_LAT > 0) ? S_WAIT : S_RESP;
            end

            S_WAIT: begin
                if (r_cnt == CNT_ONE) begin
                    w_next_state = S_RESP;
                end
            end

            S_RESP: begin
                if (r_winner_ld) begin
                    w_ld_rvalid = 1'b1;
                    w_ld_rdata  = w_resp_data;
                    w_ld_err    = w_misalign;
                end else begin
                    w_core_rvalid = 1'b1;
                    w_core_rdata  = w_resp_data;
                    w_core_err    = w_misalign;
                end
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Datapath: command latch, round-robin pointer, wait counter, read capture
    //-------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_winner_ld <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_last_ld   <= 1'b1;
            r_cnt       <= '0;
            r_rdata     <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_winner_ld <= w_pick_ld;
                r_we        <= w_pick_ld ? io_bus.ld_we    : io_bus.core_we;
                r_addr      <= w_pick_ld ? io_bus.ld_addr  : io_bus.core_addr;
                r_wdata     <= w_pick_ld ? io_bus.ld_wdata : io_bus.core_wdata;
            end

            if (r_state == S_ACCESS) begin
                r_last_ld <= r_winner_ld;
                r_cnt     <= CNT_LAT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            if (w_capture) begin
                r_rdata <= io_bus.mem_rdata;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Output drive. Address and write data are held from the latch for the
    // whole access (ACCESS and WAIT); only mem_wr marks the write cycle.
    //-------------------------------------------------------------------------
    assign io_bus.core_gnt    = w_core_gnt;
    assign io_bus.core_rvalid = w_core_rvalid;
    assign io_bus.core_rdata  = w_core_rdata;
    assign io_bus.core_err    = w_core_err;
    assign io_bus.ld_gnt      = w_ld_gnt;
    assign io_bus.ld_rvalid   = w_ld_rvalid;
    assign io_bus.ld_rdata    = w_ld_rdata;
    assign io_bus.ld_err      = w_ld_err;
    assign io_bus.mem_addr    = r_addr;
    assign io_bus.mem_wdata   = r_wdata;
    assign io_bus.mem_wr      = w_mem_wr;
    assign io_bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_data_arbiter.sv
//-----------------------------------------------------------------------------
// tb_mem_data_arbiter
//
// Self-checking bench for mem_data_arbiter. A transaction-level reference
// model keeps a timeline per access (decision cycle, grant cycle, response
// cycle), a word-addressed shadow memory and the last-served port. Every
// cycle all arbiter outputs are compared against that timeline. A directed
// prefix covers the listed scenarios; randomized traffic with withdrawals and
// mid-operation resets follows. Build with +define+MISALIGN_CHECK_EN to
// exercise the misalignment feature.
//-----------------------------------------------------------------------------
module tb_mem_data_arbiter;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 64;
    localparam int MEM_LAT   = 1;
    localparam int CORE_PRIO = 0;

`ifdef MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_data_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_data_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_LAT  (MEM_LAT),
        .CORE_PRIO(CORE_PRIO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Requester-side pending command (held on req until granted).
    typedef struct {
        bit          valid;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    req_t pc, pl;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    bit          act_valid;
    bit          act_ld;
    bit          act_we;
    bit          act_err;
    logic [63:0] act_addr;
    logic [63:0] act_wdata;
    logic [63:0] act_rdata;
    int          gnt_cyc;
    int          free_at;
    bit          last_ld;
    logic [63:0] shadow [16];

    // Stimulus knobs
    bit force_rst;
    int req_pct;   // chance (%) an idle requester raises a new request
    int wd_pct;    // chance (%) a pending request is withdrawn
    int rst_pm;    // chance (per mille) of a reset in a cycle

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        int   idx;
        int   off;
        idx     = int'($urandom_range(0, 15));
        off     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 0;
        r.valid = 1'b1;
        r.we    = $urandom_range(0, 1) == 1;
        r.addr  = 64'(idx * 8 + off);
        r.wdata = {$urandom(), $urandom()};
        return r;
    endfunction

    // One clock cycle: compare outputs at the negedge, advance the model,
    // then drive the inputs that the next rising edge will sample.
    task automatic tick();
        bit          in_access;
        bit          in_resp;
        bit          busy_exp;
        bit          rst_now;
        bit          pick_ld;
        req_t        r;
        logic [63:0] resp_data;

        @(negedge clk);

        in_access = act_valid && (cyc == gnt_cyc);
        in_resp   = act_valid && (cyc == gnt_cyc + 1 + MEM_LAT);
        busy_exp  = act_valid && (cyc >= gnt_cyc) && (cyc <= gnt_cyc + 1 + MEM_LAT);
        resp_data = (act_we || act_err) ? 64'h0 : act_rdata;

        check("core_gnt",    64'(bus.core_gnt),    64'(in_access && !act_ld));
        check("ld_gnt",      64'(bus.ld_gnt),      64'(in_access && act_ld));
        check("mem_wr",      64'(bus.mem_wr),      64'(in_access && act_we && !act_err));
        check("core_rvalid", 64'(bus.core_rvalid), 64'(in_resp && !act_ld));
        check("ld_rvalid",   64'(bus.ld_rvalid),   64'(in_resp && act_ld));
        check("core_err",    64'(bus.core_err),    64'(in_resp && !act_ld && act_err));
        check("ld_err",      64'(bus.ld_err),      64'(in_resp && act_ld && act_err));
        check("core_rdata",  bus.core_rdata, (in_resp && !act_ld) ? resp_data : 64'h0);
        check("ld_rdata",    bus.ld_rdata,   (in_resp && act_ld)  ? resp_data : 64'h0);
        check("busy",        64'(bus.busy),        64'(busy_exp));
        if (busy_exp && cyc <= gnt_cyc + MEM_LAT) begin
            check("mem_addr", bus.mem_addr, act_addr);
        end
        if (in_access && act_we) begin
            check("mem_wdata", bus.mem_wdata, act_wdata);
        end

        // Response delivered: access retired.
        if (in_resp) begin
            act_valid = 1'b0;
        end

        // Requesters drop req on seeing their grant, then may issue anew.
        if (in_access) begin
            if (act_ld) pl.valid = 1'b0;
            else        pc.valid = 1'b0;
        end
        if (req_pct > 0) begin
            if (!pc.valid && $urandom_range(0, 99) < req_pct) pc = rand_req();
            if (!pl.valid && $urandom_range(0, 99) < req_pct) pl = rand_req();
        end
        if (wd_pct > 0) begin
            if (pc.valid && $urandom_range(0, 99) < wd_pct) pc.valid = 1'b0;
            if (pl.valid && $urandom_range(0, 99) < wd_pct) pl.valid = 1'b0;
        end

        // Reset sampled at the coming edge abandons any access in flight.
        rst_now = force_rst || (rst_pm > 0 && $urandom_range(0, 999) < rst_pm);
        if (rst_now) begin
            act_valid = 1'b0;
            free_at   = cyc + 1;
            last_ld   = 1'b1;
        end

        // Arbitration decision for a request sampled at the coming edge.
        if (!rst_now && cyc >= free_at && (pc.valid || pl.valid)) begin
            pick_ld   = pl.valid && (!pc.valid || (CORE_PRIO == 0 && !last_ld));
            r         = pick_ld ? pl : pc;
            act_valid = 1'b1;
            act_ld    = pick_ld;
            act_we    = r.we;
            act_addr  = r.addr;
            act_wdata = r.wdata;
            act_err   = MIS_EN && (r.addr[2:0] != 3'b000);
            act_rdata = shadow[r.addr[6:3]];
            gnt_cyc   = cyc + 1;
            free_at   = cyc + 3 + MEM_LAT;
            last_ld   = pick_ld;
            if (act_we && !act_err) begin
                shadow[r.addr[6:3]] = r.wdata;
            end
        end

        bus.core_req   = pc.valid;
        bus.core_we    = pc.we;
        bus.core_addr  = pc.addr;
        bus.core_wdata = pc.wdata;
        bus.ld_req     = pl.valid;
        bus.ld_we      = pl.we;
        bus.ld_addr    = pl.addr;
        bus.ld_wdata   = pl.wdata;
        rst            = rst_now;
        // Memory returns valid data only in the cycle the arbiter captures it.
        bus.mem_rdata  = (act_valid && cyc == gnt_cyc + MEM_LAT) ? act_rdata
                                                                 : {$urandom(), $urandom()};
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = {$urandom(), $urandom()};
        shadow[2] = 64'hDEAD_BEEF;
        pc        = '{1'b0, 1'b0, 64'h0, 64'h0};
        pl        = '{1'b0, 1'b0, 64'h0, 64'h0};
        act_valid = 1'b0;
        act_ld    = 1'b0;
        act_we    = 1'b0;
        act_err   = 1'b0;
        act_addr  = 64'h0;
        act_wdata = 64'h0;
        act_rdata = 64'h0;
        gnt_cyc   = -10;
        free_at   = 0;
        last_ld   = 1'b1;
        force_rst = 1'b1;
        req_pct   = 0;
        wd_pct    = 0;
        rst_pm    = 0;

        bus.core_req   = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.ld_req     = 1'b0;
        bus.ld_we      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_wdata   = '0;
        bus.mem_rdata  = '0;

        // Reset state
        repeat (2) tick();
        check("rst_mem_addr",  bus.mem_addr,  64'h0);
        check("rst_mem_wdata", bus.mem_wdata, 64'h0);
        force_rst = 1'b0;

        // Core read of 0x10 returning 0xDEADBEEF
        pc = '{1'b1, 1'b0, 64'h10, 64'h0};
        repeat (6) tick();

        // Loader write 0x1234 to 0x40, then core reads it back
        pl = '{1'b1, 1'b1, 64'h40, 64'h1234};
        repeat (6) tick();
        pc = '{1'b1, 1'b0, 64'h40, 64'h0};
        repeat (6) tick();

        // Both requesters held continuously: grants alternate
        req_pct = 100;
        repeat (30) tick();
        req_pct = 0;
        repeat (8) tick();

        // Core pulses req for one cycle while a loader access is in WAIT
        pl = '{1'b1, 1'b0, 64'h8, 64'h0};
        tick();                       // request sampled
        tick();                       // ACCESS
        pc = '{1'b1, 1'b1, 64'h20, 64'hBAD};
        tick();                       // WAIT, core req high
        pc.valid = 1'b0;
        repeat (6) tick();

        // Reset during WAIT of a core read: no response may follow
        pc = '{1'b1, 1'b0, 64'h18, 64'h0};
        tick();                       // request sampled
        tick();                       // ACCESS
        force_rst = 1'b1;
        tick();                       // WAIT, reset at its closing edge
        force_rst = 1'b0;
        repeat (6) tick();

        // Core write to a misaligned address
        pc = '{1'b1, 1'b1, 64'h13, 64'hA5A5};
        repeat (6) tick();

        // Randomized traffic with withdrawals and occasional resets
        req_pct = 35;
        wd_pct  = 4;
        rst_pm  = 5;
        repeat (2000) tick();

        // Drain
        req_pct  = 0;
        wd_pct   = 0;
        rst_pm   = 0;
        pc.valid = 1'b0;
        pl.valid = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
Sequences the single data memory (Memoria64) and shares it between two requesters: the core control FSM (port "core") and a program/data loader (port "ld"). It serialises accesses, grants one requester at a time, drives the memory address, write-data and write-enable for exactly one cycle, and returns read data with a one-cycle valid pulse. It sits between MAQUINA_DE_ESTADOS/Alu_Out/MUX_ENTRADA_MEMORIA and MEM_DATA.

Parameters:
DATA_W, 64, data width of memory and requester data buses
ADDR_W, 64, address width
MEM_LAT, 1, memory read latency in cycles after the access cycle (0..7)
CORE_PRIO, 0, 1 = core always wins ties; 0 = round-robin

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
core_req  in  1  core access request; held until core_gnt
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  byte address
core_wdata  in  DATA_W  write data
core_gnt  out  1  one-cycle pulse: request accepted, access cycle in progress
core_rvalid  out  1  one-cycle pulse: access complete (read data valid / write ack)
core_rdata  out  DATA_W  read data, valid while core_rvalid
core_err  out  1  error flag qualified by core_rvalid
ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader equivalents
ld_gnt, ld_rvalid, ld_rdata, ld_err  out  1/1/DATA_W/1  loader equivalents
mem_addr  out  ADDR_W  address to memory (raddress and waddress)
mem_wdata  out  DATA_W  write data to memory
mem_wr  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state except IDLE

Behaviour:
- Clock CLK; reset RST synchronous, active-high. All state registers clear on the CLK edge where RST=1.
- Reset values: state=IDLE, all gnt/rvalid/err=0, rdata=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, last-served pointer=ld (core wins the first tie).
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: requests sampled only here. No req -> stay. One req -> that port wins. Both -> CORE_PRIO=1: core; CORE_PRIO=0: the port not last served. Winner's we/addr/wdata latched; -> ACCESS.
- ACCESS (1 cycle): winner's gnt=1; mem_addr/mem_wdata from latched values; mem_wr=latched we. Last-served pointer updated. -> WAIT if MEM_LAT>0, else -> RESP.
- WAIT: down-counter loaded with MEM_LAT, lasts exactly MEM_LAT cycles; mem_addr held, mem_wr=0. -> RESP after last cycle.
- rdata capture: mem_rdata registered at end of last WAIT cycle (or of ACCESS if MEM_LAT=0).
- RESP (1 cycle): winner's rvalid=1, rdata=captured value (writes: rdata=0); loser's outputs stay 0. -> IDLE.
- Latency: req seen in IDLE at cycle T -> gnt at T+1 -> rvalid at T+2+MEM_LAT. Throughput: one access per 3+MEM_LAT cycles.
- Requester dropping req before gnt: withdrawn, no access. req changes after gnt ignored until next IDLE.
- Request arriving during a non-IDLE state waits; no request is lost if held.
- Reset mid-operation: access abandoned, no rvalid delivered. A write in ACCESS at the reset edge has already been presented that cycle; no further mem_wr.
- mem_wr never high outside ACCESS; never two grants outstanding.

Optional Feature:
MISALIGN_CHECK_EN. Defined: latched addr[2:0]!=0 -> ACCESS still pulses gnt but mem_wr forced 0; RESP pulses rvalid with err=1 and rdata=0. Undefined: address passed unchanged, err outputs tied 0.

Test Plan:
- Core read, MEM_LAT=1, addr=0x10, mem returns 0xDEADBEEF -> core_gnt at T+1, mem_wr=0, core_rvalid at T+3, core_rdata=0xDEADBEEF, busy high T+1..T+3.
- Loader write addr=0x40 wdata=0x1234 -> mem_wr=1 only in ACCESS cycle with mem_addr=0x40, mem_wdata=0x1234; ld_rvalid at T+3.
- Both req held continuously, CORE_PRIO=0 -> grants alternate core, ld, core, ld; CORE_PRIO=1 -> core every time while core_req held.
- RST=1 during WAIT of a core read -> next cycle IDLE, busy=0, no core_rvalid ever issued for that access.
- Withdrawal: core_req pulses 1 cycle while ld access in WAIT -> no core_gnt, no memory access for core.
- MISALIGN_CHECK_EN defined, core write addr=0x13 -> mem_wr stays 0, core_rvalid=1 with core_err=1; undefined -> mem_wr=1 at addr 0x13, core_err=0.
